// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: formats each accepted beat into a 64-bit word plus
// {C,N,Z} flags, queues it in a 2-entry FIFO and keeps delivery statistics.
module alu_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [31:0] in_result,
    input  logic        in_carry,
    input  logic [63:0] in_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_opcode,
    output logic [2:0]  out_flags,
    input  logic        clr_sticky,
    output logic        sticky_carry,
    output logic [15:0] op_count
);

    logic [3:0]  r_op    [2];
    logic [63:0] r_data  [2];
    logic [2:0]  r_flags [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_sticky;
    logic [15:0] r_op_count;

    logic [63:0] w_data;
    logic        w_c;
    logic        w_n;
    logic        w_z;
    logic        w_accept;
    logic        w_deliver;
    logic [1:0]  w_count_nxt;

    // Carry is only meaningful for the add/subtract family of opcodes.
    function automatic logic carry_applies(input logic [3:0] op);
        logic res;
        case (op)
            4'd0, 4'd1, 4'd3, 4'd4: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // Format the incoming beat and derive its flags at acceptance time.
    always_comb begin
        w_data = 64'd0;
        w_c    = 1'b0;
        w_n    = 1'b0;
        if (in_opcode == 4'd2) begin
            w_data = in_product;
            w_n    = in_product[63];
        end else begin
            w_data = {32'h0000_0000, in_result};
            w_n    = in_result[31];
        end
        if (carry_applies(in_opcode)) begin
            w_c = in_carry;
        end else begin
            w_c = 1'b0;
        end
        w_z = (w_data == 64'd0);
    end

    // Next occupancy: simultaneous accept and deliver leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_deliver})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage, pointers, handshake flags and delivery statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_op[i]    <= 4'd0;
                r_data[i]  <= 64'd0;
                r_flags[i] <= 3'd0;
            end
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sticky    <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op[r_wr_ptr]    <= in_opcode;
                r_data[r_wr_ptr]  <= w_data;
                r_flags[r_wr_ptr] <= {w_c, w_n, w_z};
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_deliver) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_op_count != 16'hFFFF) begin
                    r_op_count <= r_op_count + 16'd1;
                end else begin
                    r_op_count <= r_op_count;
                end
            end else begin
                r_rd_ptr   <= r_rd_ptr;
                r_op_count <= r_op_count;
            end
            // A carry being delivered takes priority over a clear request.
            if (w_deliver && r_flags[r_rd_ptr][2]) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end else begin
                r_sticky <= r_sticky;
            end
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < 2'd2);
            r_out_valid <= (w_count_nxt != 2'd0);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_data[r_rd_ptr];
    assign out_opcode   = r_op[r_rd_ptr];
    assign out_flags    = r_flags[r_rd_ptr];
    assign sticky_carry = r_sticky;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_result;
    logic        in_carry;
    logic [63:0] in_product;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_opcode;
    logic [2:0]  out_flags;
    logic        clr_sticky;
    logic        sticky_carry;
    logic [15:0] op_count;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_product   (in_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_opcode   (out_opcode),
        .out_flags    (out_flags),
        .clr_sticky   (clr_sticky),
        .sticky_carry (sticky_carry),
        .op_count     (op_count)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] data;
        logic [2:0]  flags;
    } ent_t;

    ent_t        m_q[$];
    logic [15:0] m_cnt;
    logic        m_sticky;
    bit          started;
    int          n_tests;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic ent_t make_entry(input logic [3:0] op, input logic [31:0] res,
                                        input logic c, input logic [63:0] prod);
        ent_t e;
        e.op   = op;
        e.data = (op == 4'd2) ? prod : {32'h0, res};
        e.flags[2] = (op == 4'd0 || op == 4'd1 || op == 4'd3 || op == 4'd4) ? c : 1'b0;
        e.flags[1] = (op == 4'd2) ? e.data[63] : e.data[31];
        e.flags[0] = (e.data == 64'd0);
        return e;
    endfunction

    // Reference model: advances on every rising edge from the inputs seen there.
    initial begin
        ent_t e;
        bit   acc;
        bit   del;
        started  = 0;
        m_cnt    = 16'd0;
        m_sticky = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_cnt    = 16'd0;
                m_sticky = 1'b0;
                started  = 1;
            end else if (started) begin
                acc = in_valid && (m_q.size() < 2);
                del = (m_q.size() > 0) && out_ready;
                if (del) begin
                    e = m_q.pop_front();
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    if (e.flags[2]) m_sticky = 1'b1;
                    else if (clr_sticky) m_sticky = 1'b0;
                end else if (clr_sticky) begin
                    m_sticky = 1'b0;
                end
                if (acc) m_q.push_back(make_entry(in_opcode, in_result, in_carry, in_product));
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, (m_q.size() < 2) ? 64'd1 : 64'd0);
            chk("out_valid", out_valid, (m_q.size() > 0) ? 64'd1 : 64'd0);
            if (m_q.size() > 0) begin
                chk("out_data", out_data, m_q[0].data);
                chk("out_opcode", out_opcode, m_q[0].op);
                chk("out_flags", out_flags, m_q[0].flags);
            end
            chk("op_count", op_count, m_cnt);
            chk("sticky_carry", sticky_carry, m_sticky);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] op, input logic [31:0] res,
                        input logic c, input logic [63:0] prod);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_result  = res;
        in_carry   = c;
        in_product = prod;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = 4'd0;
        in_result  = 32'd0;
        in_carry   = 1'b0;
        in_product = 64'd0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_opcode", out_opcode, 64'd0);
        chk("rst_out_flags", out_flags, 64'd0);
        chk("rst_op_count", op_count, 64'd0);
        chk("rst_sticky", sticky_carry, 64'd0);

        // ADD of zero with carry
        beat(4'd0, 32'd0, 1'b1, 64'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_valid", out_valid, 64'd1);
        chk("add_data", out_data, 64'd0);
        chk("add_flags", out_flags, 64'h5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("add_op_count", op_count, 64'd1);
        chk("add_sticky", sticky_carry, 64'd1);

        // MUL with negative 64-bit product; carry must be masked
        beat(4'd2, 32'h1234, 1'b1, 64'h8000_0000_0000_0001);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_data", out_data, 64'h8000_0000_0000_0001);
        chk("mul_flags", out_flags, 64'h2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Backpressure: three beats, third held until space
        beat(4'd2, 32'd0, 1'b0, 64'h0000_0001_0000_0000);
        step();
        beat(4'd13, 32'h8000_0000, 1'b1, 64'd0);
        step();
        beat(4'd1, 32'd7, 1'b1, 64'd0);
        step();
        @(negedge clk);
        chk("full_in_ready", in_ready, 64'd0);
        chk("full_head_op", out_opcode, 64'd2);
        chk("full_head_flags", out_flags, 64'd0);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("full_deliver_in_ready", in_ready, 64'd1);
        chk("second_op", out_opcode, 64'd13);
        chk("second_flags", out_flags, 64'h2);
        chk("second_count", op_count, 64'd3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("third_op", out_opcode, 64'd1);
        chk("third_flags", out_flags, 64'h4);
        chk("third_count", op_count, 64'd4);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_valid", out_valid, 64'd0);
        chk("drain_count", op_count, 64'd5);

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("clr_sticky", sticky_carry, 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            beat(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()});
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            clr_sticky = ($urandom_range(0, 7) == 0);
            step();
        end
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        step();

        // Reset with two entries stored and a beat presented
        out_ready = 1'b0;
        beat(4'd3, 32'd5, 1'b1, 64'd0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 64'd0);
        chk("mid_rst_in_ready", in_ready, 64'd1);
        chk("mid_rst_count", op_count, 64'd0);
        chk("mid_rst_sticky", sticky_carry, 64'd0);
        step();
        @(negedge clk);
        chk("mid_rst_no_accept", out_valid, 64'd0);

        // Stream 65534 deliveries back to back
        out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            beat(4'(i), $urandom(), 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
            step();
        end
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("count_fffe", op_count, 64'hFFFE);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        out_ready  = 1'b0;
        beat(4'd5, 32'd1, 1'b0, 64'd0);
        step();
        beat(4'd0, 32'd5, 1'b1, 64'd0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("count_ffff", op_count, 64'hFFFF);
        chk("sticky_before_set", sticky_carry, 64'd0);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("sticky_set_wins", sticky_carry, 64'd1);
        chk("count_hold", op_count, 64'hFFFF);
        beat(4'd4, 32'd0, 1'b1, 64'd0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("count_saturate", op_count, 64'hFFFF);
        chk("final_empty", out_valid, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream ALU output is valid this cycle.
REQ-005 in_ready  output  1  stage can accept a beat this cycle.
REQ-006 in_opcode  input  4  opcode issued with the beat (0 ADD, 1 SUB, 2 MUL, 3 INCR, 4 DECR, 5-11 logic, 12-15 shifts).
REQ-007 in_result  input  32  ALU result word.
REQ-008 in_carry  input  1  ALU carry_out.
REQ-009 in_product  input  64  ALU multiplier product.
REQ-010 out_valid  output  1  head entry is presented.
REQ-011 out_ready  input  1  downstream accepts the head entry.
REQ-012 out_data  output  64  formatted result of the head entry.
REQ-013 out_opcode  output  4  opcode of the head entry.
REQ-014 out_flags  output  3  {C,N,Z} of the head entry.
REQ-015 clr_sticky  input  1  clear request for sticky_carry.
REQ-016 sticky_carry  output  1  set when any delivered beat had C=1.
REQ-017 op_count  output  16  number of delivered beats, saturating.

Function
REQ-018 The stage SHALL hold a 2-entry FIFO of {opcode, data[63:0], flags[2:0]}.
REQ-019 Accept when in_valid && in_ready; deliver when out_valid && out_ready.
REQ-020 in_ready SHALL be 1 iff occupancy < 2, registered-state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 iff occupancy > 0; no bypass: an accepted beat appears on out_* at the earliest one cycle after acceptance.
REQ-022 Occupancy: accept only +1; deliver only -1; accept and deliver same cycle: unchanged, FIFO order preserved.
REQ-023 When full, in_valid is ignored (in_ready=0) even if out_ready=1 that cycle.
REQ-024 out_* SHALL stay stable while out_valid && !out_ready.
REQ-025 Data format: opcode 2 -> data = in_product; otherwise data = {32'h0, in_result}.
REQ-026 C = in_carry for opcodes 0,1,3,4; C = 0 for all others.
REQ-027 N = data[63] for opcode 2, data[31] otherwise.
REQ-028 Z = 1 iff all 64 bits of data are zero.
REQ-029 Flags SHALL be computed at acceptance and stored with the entry.
REQ-030 op_count increments by 1 per delivered beat; holds at 16'hFFFF (no wrap).
REQ-031 sticky_carry: set on a delivered beat with C=1; cleared by clr_sticky; simultaneous set and clear -> 1 (set wins).
REQ-032 Read and write pointers are 1 bit each and wrap 1->0.

Reset
REQ-033 While rst=1 at a clock edge: occupancy 0, pointers 0, out_valid 0, in_ready 1 after the edge, out_data 0, out_opcode 0, out_flags 0, op_count 0, sticky_carry 0.
REQ-034 Reset mid-operation SHALL discard all stored entries; a beat presented with in_valid=1 in the reset cycle is not accepted.

Verification
REQ-035 ADD beat result=0, carry=1 -> next cycle out_valid=1, out_data=0, flags C=1,N=0,Z=1; after delivery op_count=1, sticky_carry=1.
REQ-036 MUL beat product=64'h8000_0000_0000_0001, carry=1 -> out_data equals product, C=0, N=1, Z=0.
REQ-037 out_ready=0, three consecutive beats -> first two accepted, in_ready=0 on third; release out_ready -> beats delivered in order, third held by upstream until space.
REQ-038 Full FIFO, in_valid=1 and out_ready=1 same cycle -> one delivery, no acceptance; next cycle occupancy 1, in_ready=1.
REQ-039 Preload op_count to 16'hFFFE via 65534 deliveries, deliver 2 more -> op_count=16'hFFFF; clr_sticky coincident with a C=1 delivery -> sticky_carry=1.
REQ-040 Assert rst with 2 entries stored -> next cycle out_valid=0, in_ready=1, op_count=0, sticky_carry=0.
